// File: rtl/tq_ram_sp_fifo_ctrl_pkg.sv
// Shared widths and sizes for the TQ single-port-RAM FIFO controller.
// Latency: n/a (constants only).
// Backpressure: n/a.
package tq_ram_sp_fifo_ctrl_pkg;

    localparam int TQ_FIFO_DATA_WD  = 16;  // sample width, equals RAM word width
    localparam int TQ_FIFO_ADDR_WD  = 5;   // RAM address width, 32 words
    localparam int TQ_FIFO_OQ_DEPTH = 2;   // output queue entries behind the RAM
    localparam int TQ_FIFO_CNT_WD   = 6;   // occupancy width, 0..34

endpackage

// File: rtl/tq_fifo_outq.sv
// Two-entry register queue catching RAM read data in front of the read stream.
// Latency: a push is visible on out_vld/out_dat the cycle after it is pushed.
// Backpressure: pops on out_vld & out_rdy; caller must never push into a full queue.
//
// Ports: clk, rst_n (async, active low), flush (sync clear), in_vld/in_dat (push),
//        out_vld/out_rdy/out_dat (head and pop), cnt (entries held, 0..2).
module tq_fifo_outq #(
    parameter int DATA_WD = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_vld,
    input  logic [DATA_WD-1:0] in_dat,
    output logic               out_vld,
    input  logic               out_rdy,
    output logic [DATA_WD-1:0] out_dat,
    output logic [1:0]         cnt
);

    logic [DATA_WD-1:0] head_q;
    logic [DATA_WD-1:0] tail_q;
    logic [1:0]         cnt_q;
    logic               pop;

    assign pop     = out_vld & out_rdy;
    assign out_vld = (cnt_q != 2'd0);
    assign out_dat = head_q;
    assign cnt     = cnt_q;

    // Head is always entry 0; a pop shifts the tail forward.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
        end else if (flush) begin
            cnt_q <= 2'd0;
        end else begin
            case ({in_vld, pop})
                2'b10: begin
                    if (cnt_q == 2'd0) head_q <= in_dat;
                    else               tail_q <= in_dat;
                    cnt_q <= cnt_q + 2'd1;
                end
                2'b01: begin
                    head_q <= tail_q;
                    cnt_q  <= cnt_q - 2'd1;
                end
                2'b11: begin
                    // Count is unchanged; with one entry the new word replaces the head.
                    if (cnt_q == 2'd2) begin
                        head_q <= tail_q;
                        tail_q <= in_dat;
                    end else begin
                        head_q <= in_dat;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/tq_ram_sp_fifo_ctrl.sv
// Drives the 32x16 single-port TQ RAM as a FIFO with valid/ready write and read streams.
// Latency: word written into an empty FIFO appears on rd_val_o two edges after acceptance.
// Backpressure: wr_rdy_o drops when RAM is full or a read launch owns the port; reads stall via rd_rdy_i.
//
// Ports: clk, rst_n (async, active low), flush_i (sync clear),
//        wr_val_i/wr_rdy_o/wr_dat_i (write stream), rd_val_o/rd_rdy_i/rd_dat_o (read stream),
//        ram_cen_o/ram_wen_o (active-low strobes), ram_addr_o, ram_dat_o, ram_dat_i (RAM port),
//        cnt_o (total occupancy, only computed when TQ_FIFO_CNT_EN is defined, else 0).
module tq_ram_sp_fifo_ctrl
    import tq_ram_sp_fifo_ctrl_pkg::*;
#(
    parameter int DATA_WD = TQ_FIFO_DATA_WD,
    parameter int ADDR_WD = TQ_FIFO_ADDR_WD
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush_i,
    input  logic                      wr_val_i,
    output logic                      wr_rdy_o,
    input  logic [DATA_WD-1:0]        wr_dat_i,
    output logic                      rd_val_o,
    input  logic                      rd_rdy_i,
    output logic [DATA_WD-1:0]        rd_dat_o,
    output logic                      ram_cen_o,
    output logic                      ram_wen_o,
    output logic [ADDR_WD-1:0]        ram_addr_o,
    output logic [DATA_WD-1:0]        ram_dat_o,
    input  logic [DATA_WD-1:0]        ram_dat_i,
    output logic [TQ_FIFO_CNT_WD-1:0] cnt_o
);

    localparam logic [ADDR_WD:0]   RAM_FULL = {1'b1, {ADDR_WD{1'b0}}};
    localparam logic [ADDR_WD:0]   CNT_ONE  = {{ADDR_WD{1'b0}}, 1'b1};
    localparam logic [ADDR_WD-1:0] PTR_ONE  = {{(ADDR_WD-1){1'b0}}, 1'b1};
    localparam logic [2:0]         OQ_DEPTH = 3'(TQ_FIFO_OQ_DEPTH);

    logic               rst_done_q;
    logic [ADDR_WD-1:0] wr_ptr_q;
    logic [ADDR_WD-1:0] rd_ptr_q;
    logic [ADDR_WD:0]   ram_cnt_q;
    logic               infl_q;
    logic               wr_pri_q;

    logic [1:0] oq_cnt;
    logic       oq_vld;
    logic       rd_pop;
    logic       rd_need;
    logic       wr_go;
    logic       rd_go;
    logic [2:0] oq_fill;
    logic [2:0] oq_lim;

    // A launch is worthwhile only if the queue can still hold its result once
    // this cycle's pop and the word already in flight are accounted for.
    assign rd_pop  = oq_vld & rd_rdy_i;
    assign oq_fill = {1'b0, oq_cnt} + {2'b00, infl_q};
    assign oq_lim  = OQ_DEPTH + {2'b00, rd_pop};
    assign rd_need = (ram_cnt_q != '0) & (oq_fill < oq_lim);

    // wr_pri_q set means the last port op was a read, so a waiting write wins.
    assign wr_rdy_o = rst_done_q & (ram_cnt_q != RAM_FULL) & ~flush_i & ~(rd_need & ~wr_pri_q);
    assign wr_go    = wr_val_i & wr_rdy_o;
    assign rd_go    = rd_need & ~flush_i & ~wr_go;

    assign ram_cen_o  = ~(wr_go | rd_go);
    assign ram_wen_o  = ~wr_go;
    assign ram_addr_o = wr_go ? wr_ptr_q : rd_ptr_q;
    assign ram_dat_o  = wr_dat_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_done_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ram_cnt_q  <= '0;
            infl_q     <= 1'b0;
            wr_pri_q   <= 1'b0;
        end else begin
            rst_done_q <= 1'b1;
            if (flush_i) begin
                wr_ptr_q  <= '0;
                rd_ptr_q  <= '0;
                ram_cnt_q <= '0;
                infl_q    <= 1'b0;
                wr_pri_q  <= 1'b0;
            end else begin
                infl_q <= rd_go;
                if (wr_go) begin
                    wr_ptr_q  <= wr_ptr_q + PTR_ONE;
                    ram_cnt_q <= ram_cnt_q + CNT_ONE;
                    wr_pri_q  <= 1'b0;
                end else if (rd_go) begin
                    rd_ptr_q  <= rd_ptr_q + PTR_ONE;
                    ram_cnt_q <= ram_cnt_q - CNT_ONE;
                    wr_pri_q  <= 1'b1;
                end
            end
        end
    end

    // RAM data is valid the cycle after the read strobe; a flush drops it.
    tq_fifo_outq #(
        .DATA_WD (DATA_WD)
    ) u_outq (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush_i),
        .in_vld  (infl_q),
        .in_dat  (ram_dat_i),
        .out_vld (oq_vld),
        .out_rdy (rd_rdy_i),
        .out_dat (rd_dat_o),
        .cnt     (oq_cnt)
    );

    assign rd_val_o = oq_vld;

`ifdef TQ_FIFO_CNT_EN
    assign cnt_o = TQ_FIFO_CNT_WD'(ram_cnt_q) + TQ_FIFO_CNT_WD'(infl_q) + TQ_FIFO_CNT_WD'(oq_cnt);
`else
    assign cnt_o = '0;
`endif

endmodule

// File: tb/tb_tq_ram_sp_fifo_ctrl.sv
// Bench for tq_ram_sp_fifo_ctrl with a behavioural 32x16 RAM and a data scoreboard.
// Latency: n/a.
// Backpressure: consumer ready is driven directly per cycle.
module tb_tq_ram_sp_fifo_ctrl;

    logic        clk;
    logic        rst_n;
    logic        flush_i;
    logic        wr_val_i;
    logic        wr_rdy_o;
    logic [15:0] wr_dat_i;
    logic        rd_val_o;
    logic        rd_rdy_i;
    logic [15:0] rd_dat_o;
    logic        ram_cen_o;
    logic        ram_wen_o;
    logic [4:0]  ram_addr_o;
    logic [15:0] ram_dat_o;
    logic [15:0] ram_dat_i;
    logic [5:0]  cnt_o;

`ifdef TQ_FIFO_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    tq_ram_sp_fifo_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (flush_i),
        .wr_val_i   (wr_val_i),
        .wr_rdy_o   (wr_rdy_o),
        .wr_dat_i   (wr_dat_i),
        .rd_val_o   (rd_val_o),
        .rd_rdy_i   (rd_rdy_i),
        .rd_dat_o   (rd_dat_o),
        .ram_cen_o  (ram_cen_o),
        .ram_wen_o  (ram_wen_o),
        .ram_addr_o (ram_addr_o),
        .ram_dat_o  (ram_dat_o),
        .ram_dat_i  (ram_dat_i),
        .cnt_o      (cnt_o)
    );

    // Behavioural single-port RAM: read data one cycle after the strobe.
    logic [15:0] mem [32];
    always @(posedge clk) begin
        if (!ram_cen_o) begin
            if (!ram_wen_o) mem[ram_addr_o] <= ram_dat_o;
            else            ram_dat_i <= mem[ram_addr_o];
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_chk;
    int          n_fail;
    logic [15:0] sb [$];
    logic [4:0]  wa;
    logic [4:0]  ra;
    logic [4:0]  last_wa;
    int          n_wstb;
    int          n_rstb;
    int          n_pop;
    logic [15:0] last_pop;
    bit          wrap_seen;
    bit          mon_en;

    typedef struct {
        logic        flush;
        logic        wr_val;
        logic [15:0] wr_dat;
        logic        rd_rdy;
        logic        wr_rdy;
        logic        cen;
        logic        wen;
        logic [4:0]  addr;
        logic        rd_val;
        logic [15:0] rd_dat;
        int          cnt;
    } vec_t;
    vec_t tbl [5];

    function automatic logic [5:0] exp_cnt(input int n);
        return CNT_EN ? 6'(n) : 6'd0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply(input logic f, input logic wv, input logic [15:0] wd, input logic rr);
        @(negedge clk);
        flush_i  = f;
        wr_val_i = wv;
        wr_dat_i = wd;
        rd_rdy_i = rr;
    endtask

    // Checks port protocol and data order for the current cycle, then advances one edge.
    task automatic tick();
        logic        acc;
        logic [15:0] exp_d;
        #2;
        if (mon_en) begin
            acc = wr_val_i & wr_rdy_o;
            chk("cnt", cnt_o, exp_cnt(sb.size()));
            chk("wr_strobe", !ram_cen_o && !ram_wen_o, acc);
            if (!ram_cen_o && !ram_wen_o) begin
                chk("wr_addr", ram_addr_o, wa);
                chk("wr_data", ram_dat_o, wr_dat_i);
                if (last_wa == 5'd31 && ram_addr_o == 5'd0) wrap_seen = 1'b1;
                last_wa = ram_addr_o;
                wa = wa + 5'd1;
                n_wstb++;
            end
            if (!ram_cen_o && ram_wen_o) begin
                chk("rd_addr", ram_addr_o, ra);
                ra = ra + 5'd1;
                n_rstb++;
            end
            if (rd_val_o && rd_rdy_i) begin
                chk("pop_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    exp_d = sb.pop_front();
                    chk("rd_data", rd_dat_o, exp_d);
                end
                last_pop = rd_dat_o;
                n_pop++;
            end
            if (acc) sb.push_back(wr_dat_i);
            if (flush_i) begin
                sb.delete();
                wa = 5'd0;
                ra = 5'd0;
            end
        end
        @(posedge clk);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200; i++) begin
            if (sb.size() == 0 && !rd_val_o) break;
            apply(1'b0, 1'b0, 16'h0000, 1'b1);
            tick();
        end
        chk(name, sb.size(), 0);
    endtask

    initial begin
        int   k;
        int   p0;
        int   w0;
        int   r0;
        logic acc;

        n_chk = 0; n_fail = 0; n_wstb = 0; n_rstb = 0; n_pop = 0;
        wa = 5'd0; ra = 5'd0; last_wa = 5'd0; last_pop = 16'h0;
        wrap_seen = 1'b0; mon_en = 1'b0;
        rst_n = 1'b0; flush_i = 1'b0; wr_val_i = 1'b0; wr_dat_i = 16'h5A5A; rd_rdy_i = 1'b0;

        //            flush wv   wdat     rr    wrdy cen  wen  addr  rval rdat     cnt
        tbl[0] = '{1'b0, 1'b1, 16'h1234, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 16'h0000, 0};
        tbl[1] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 16'h0000, 1};
        tbl[2] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 5'd1, 1'b0, 16'h0000, 1};
        tbl[3] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 5'd1, 1'b1, 16'h1234, 1};
        tbl[4] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 5'd1, 1'b0, 16'h0000, 0};

        // Reset values
        #12;
        chk("rst_rd_val", rd_val_o, 0);
        chk("rst_rd_dat", rd_dat_o, 0);
        chk("rst_cnt", cnt_o, 0);
        chk("rst_cen", ram_cen_o, 1);
        chk("rst_wen", ram_wen_o, 1);
        chk("rst_addr", ram_addr_o, 0);
        chk("rst_ram_dat", ram_dat_o, 16'h5A5A);
        chk("rst_wr_rdy", wr_rdy_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wr_dat_i = 16'h0000;
        #1;
        chk("rel_wr_rdy_pre_edge", wr_rdy_o, 0);
        mon_en = 1'b1;
        tick();

        // Single write/read, cycle by cycle
        for (int i = 0; i < 5; i++) begin
            apply(tbl[i].flush, tbl[i].wr_val, tbl[i].wr_dat, tbl[i].rd_rdy);
            #1;
            chk($sformatf("v%0d_wr_rdy", i), wr_rdy_o, tbl[i].wr_rdy);
            chk($sformatf("v%0d_cen", i), ram_cen_o, tbl[i].cen);
            chk($sformatf("v%0d_wen", i), ram_wen_o, tbl[i].wen);
            chk($sformatf("v%0d_addr", i), ram_addr_o, tbl[i].addr);
            chk($sformatf("v%0d_rd_val", i), rd_val_o, tbl[i].rd_val);
            if (tbl[i].rd_val) chk($sformatf("v%0d_rd_dat", i), rd_dat_o, tbl[i].rd_dat);
            chk($sformatf("v%0d_cnt", i), cnt_o, exp_cnt(tbl[i].cnt));
            tick();
        end

        // Fill to full with the consumer stalled: 32 in RAM + 2 in the queue
        k = 0;
        for (int i = 0; i < 80; i++) begin
            apply(1'b0, 1'b1, 16'(k), 1'b0);
            #1;
            acc = wr_rdy_o;
            tick();
            if (acc) k++;
        end
        apply(1'b0, 1'b0, 16'h0000, 1'b0);
        #1;
        chk("fill_accepts", k, 34);
        chk("full_wr_rdy", wr_rdy_o, 0);
        chk("full_rd_val", rd_val_o, 1);
        chk("full_cnt", cnt_o, exp_cnt(34));
        tick();
        // Drain at one word per cycle, order checked by the scoreboard
        for (int i = 0; i < 34; i++) begin
            apply(1'b0, 1'b0, 16'h0000, 1'b1);
            tick();
        end
        apply(1'b0, 1'b0, 16'h0000, 1'b0);
        #1;
        chk("drain_rate_empty", sb.size(), 0);
        chk("drain_rd_val", rd_val_o, 0);
        tick();

        // Concurrent saturation from empty: strict alternation
        w0 = n_wstb; r0 = n_rstb;
        for (int i = 0; i < 40; i++) begin
            apply(1'b0, 1'b1, 16'h1000 + 16'(i), 1'b1);
            tick();
        end
        chk("sat_writes", n_wstb - w0, 20);
        chk("sat_reads", n_rstb - r0, 20);
        drain("sat_drain");

        // Pointer wrap with random consumer stalls
        wrap_seen = 1'b0;
        p0 = n_pop;
        k = 0;
        for (int i = 0; i < 1000 && k < 100; i++) begin
            apply(1'b0, 1'b1, 16'h2000 + 16'(k), 1'($urandom_range(0, 1)));
            #1;
            acc = wr_rdy_o;
            tick();
            if (acc) k++;
        end
        chk("wrap_accepts", k, 100);
        drain("wrap_drain");
        chk("wrap_pops", n_pop - p0, 100);
        chk("wrap_seen", wrap_seen, 1);

        // Flush with a read in flight
        apply(1'b0, 1'b1, 16'hAAAA, 1'b0);
        tick();
        apply(1'b0, 1'b0, 16'h0000, 1'b0);
        #1;
        chk("fl_rd_strobe", {ram_cen_o, ram_wen_o}, 2'b01);
        tick();
        apply(1'b1, 1'b1, 16'h7777, 1'b0);
        #1;
        chk("fl_no_strobe", ram_cen_o, 1);
        chk("fl_wr_rdy", wr_rdy_o, 0);
        tick();
        apply(1'b0, 1'b0, 16'h0000, 1'b0);
        #1;
        chk("fl_rd_val", rd_val_o, 0);
        chk("fl_cnt", cnt_o, exp_cnt(0));
        tick();
        p0 = n_pop;
        apply(1'b0, 1'b1, 16'hBEEF, 1'b1);
        tick();
        drain("fl_drain");
        chk("fl_pop_cnt", n_pop - p0, 1);
        chk("fl_pop_dat", last_pop, 16'hBEEF);

        // Asynchronous reset in the middle of a saturated burst
        for (int i = 0; i < 7; i++) begin
            apply(1'b0, 1'b1, 16'h3000 + 16'(i), 1'b1);
            tick();
        end
        @(negedge clk);
        #1;
        chk("pre_rst_rd_val", rd_val_o, 1);
        rst_n = 1'b0;
        mon_en = 1'b0;
        #1;
        chk("arst_rd_val", rd_val_o, 0);
        chk("arst_rd_dat", rd_dat_o, 0);
        chk("arst_cnt", cnt_o, 0);
        chk("arst_cen", ram_cen_o, 1);
        chk("arst_wen", ram_wen_o, 1);
        chk("arst_addr", ram_addr_o, 0);
        chk("arst_wr_rdy", wr_rdy_o, 0);
        @(negedge clk);
        wr_val_i = 1'b0;
        rd_rdy_i = 1'b0;
        @(negedge clk);
        chk("arst_hold_wr_rdy", wr_rdy_o, 0);
        rst_n = 1'b1;
        sb.delete();
        wa = 5'd0;
        ra = 5'd0;
        #1;
        chk("arst_rel_wr_rdy", wr_rdy_o, 0);
        @(posedge clk);
        #1;
        chk("arst_post_wr_rdy", wr_rdy_o, 1);
        mon_en = 1'b1;
        p0 = n_pop;
        apply(1'b0, 1'b1, 16'h0055, 1'b1);
        tick();
        drain("arst_drain");
        chk("arst_pop_cnt", n_pop - p0, 1);
        chk("arst_pop_dat", last_pop, 16'h0055);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
